// File: rtl/neokeon_pkg.sv
// Shared Noekeon types, round constants, FSM encoding and the Pi1/Gamma/Pi2 function blocks.
package neokeon_pkg;

    localparam int unsigned NR = 16;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam logic [7:0] RC [0:NR] = '{
        8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
        8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4
    };

    typedef enum logic [1:0] {
        StIdle,
        StKeyPrep,
        StRound,
        StFinal
    } fsm_t;

    function automatic word_t rotl32(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic word_t rotr32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic state_t pi1(input state_t s);
        return {s[127:96], rotl32(s[95:64], 1), rotl32(s[63:32], 5), rotl32(s[31:0], 2)};
    endfunction

    function automatic state_t pi2(input state_t s);
        return {s[127:96], rotr32(s[95:64], 1), rotr32(s[63:32], 5), rotr32(s[31:0], 2)};
    endfunction

    function automatic state_t gamma(input state_t s);
        word_t a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = s;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

endpackage

// File: rtl/neokeon_decrypt_core_if.sv
// Start/busy/done handshake and data bus of the Noekeon decryption core.
interface neokeon_decrypt_core_if;
    import neokeon_pkg::*;

    logic   inStart;
    state_t inKey;
    state_t inDataState;
    state_t outDataState;
    logic   outBusy;
    logic   outDone;

    modport master (
        output inStart, inKey, inDataState,
        input  outDataState, outBusy, outDone
    );

    modport slave (
        input  inStart, inKey, inDataState,
        output outDataState, outBusy, outDone
    );

endinterface

// File: rtl/neokeon_theta.sv
// Combinational Noekeon Theta: linear diffusion with the key XOR in the middle.
module neokeon_theta
    import neokeon_pkg::*;
(
    input  state_t i_key,
    input  state_t i_state,
    output state_t o_state
);

    word_t w_a0, w_a1, w_a2, w_a3;
    word_t w_t0, w_t1;

    always_comb begin
        {w_a0, w_a1, w_a2, w_a3} = i_state;
        w_t0 = w_a0 ^ w_a2;
        w_t0 = w_t0 ^ rotl32(w_t0, 8) ^ rotr32(w_t0, 8);
        w_a1 = w_a1 ^ w_t0;
        w_a3 = w_a3 ^ w_t0;
        w_a0 = w_a0 ^ i_key[127:96];
        w_a1 = w_a1 ^ i_key[95:64];
        w_a2 = w_a2 ^ i_key[63:32];
        w_a3 = w_a3 ^ i_key[31:0];
        w_t1 = w_a1 ^ w_a3;
        w_t1 = w_t1 ^ rotl32(w_t1, 8) ^ rotr32(w_t1, 8);
        w_a0 = w_a0 ^ w_t1;
        w_a2 = w_a2 ^ w_t1;
        o_state = {w_a0, w_a1, w_a2, w_a3};
    end

endmodule

// File: rtl/neokeon_decrypt_core.sv
// Iterative Noekeon-128 decryption core, direct-key mode, one round per clock.
// Optional NEOKEON_KEYCACHE_EN: reuse the prepared key when the raw key repeats.
module neokeon_decrypt_core
    import neokeon_pkg::*;
#(
    parameter int unsigned ROUNDS = NR
) (
    input logic                   inClk,
    input logic                   inRst,
    neokeon_decrypt_core_if.slave bus
);

    localparam logic [4:0] RcStart = 5'(ROUNDS);

    fsm_t       r_fsm, w_fsm_next;
    state_t     r_state, w_state_next;
    state_t     r_key, w_key_next;
    state_t     r_out, w_out_next;
    logic [4:0] r_rc_idx, w_rc_idx_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;

    state_t w_theta_key, w_theta_in, w_theta_out;
    state_t w_rc_mixed, w_round_out;
    logic   w_accept;

    assign w_accept = bus.inStart && !r_busy;

    // One Theta instance: key preparation during KEYPREP, state update otherwise.
    always_comb begin
        w_theta_key = r_key;
        w_theta_in  = r_state;
        if (r_fsm == StKeyPrep) begin
            w_theta_key = '0;
            w_theta_in  = r_key;
        end
    end

    neokeon_theta u_theta (
        .i_key   (w_theta_key),
        .i_state (w_theta_in),
        .o_state (w_theta_out)
    );

    assign w_rc_mixed  = w_theta_out ^ {24'h0, RC[r_rc_idx], 96'h0};
    assign w_round_out = pi2(gamma(pi1(w_rc_mixed)));

`ifdef NEOKEON_KEYCACHE_EN
    logic   r_cache_vld;
    state_t r_cache_raw;
    state_t r_cache_prep;
    logic   w_hit;

    assign w_hit = r_cache_vld && (bus.inKey == r_cache_raw);

    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_cache_vld  <= 1'b0;
            r_cache_raw  <= '0;
            r_cache_prep <= '0;
        end else if (r_fsm == StKeyPrep) begin
            r_cache_vld  <= 1'b1;
            r_cache_raw  <= r_key;
            r_cache_prep <= w_theta_out;
        end
    end
`endif

    always_comb begin
        w_fsm_next    = r_fsm;
        w_state_next  = r_state;
        w_key_next    = r_key;
        w_out_next    = r_out;
        w_rc_idx_next = r_rc_idx;
        w_done_next   = 1'b0;
        unique case (r_fsm)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = bus.inDataState;
                    w_key_next   = bus.inKey;
                    w_fsm_next   = StKeyPrep;
`ifdef NEOKEON_KEYCACHE_EN
                    if (w_hit) begin
                        w_key_next    = r_cache_prep;
                        w_rc_idx_next = RcStart;
                        w_fsm_next    = StRound;
                    end
`endif
                end
            end
            StKeyPrep: begin
                w_key_next    = w_theta_out;
                w_rc_idx_next = RcStart;
                w_fsm_next    = StRound;
            end
            StRound: begin
                w_state_next  = w_round_out;
                w_rc_idx_next = r_rc_idx - 5'd1;
                if (r_rc_idx == 5'd1) begin
                    w_fsm_next = StFinal;
                end
            end
            StFinal: begin
                // rc_idx has counted down to 0 here, so RC[0] is applied
                w_out_next  = w_rc_mixed;
                w_done_next = 1'b1;
                w_fsm_next  = StIdle;
            end
            default: w_fsm_next = StIdle;
        endcase
        // Busy covers the done cycle so a start alongside outDone is refused.
        w_busy_next = (w_fsm_next != StIdle) || w_done_next;
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_fsm    <= StIdle;
            r_state  <= '0;
            r_key    <= '0;
            r_out    <= '0;
            r_rc_idx <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_next;
            r_state  <= w_state_next;
            r_key    <= w_key_next;
            r_out    <= w_out_next;
            r_rc_idx <= w_rc_idx_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.outDataState = r_out;
    assign bus.outBusy      = r_busy;
    assign bus.outDone      = r_done;

endmodule

// File: tb/tb_neokeon_decrypt_core.sv
// Bench for neokeon_decrypt_core: word-level Noekeon model, per-cycle compare, directed vectors.
module tb_neokeon_decrypt_core;

    typedef logic [31:0] w_t;

`ifdef NEOKEON_KEYCACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    localparam logic [127:0] KatCt = 128'hb1656851699e29fa24b70148503d2dfc;
    localparam logic [127:0] RtKey = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] RtPt  = 128'h6954e6d2713150fa99d8dc6fd246cddc;

    logic clk;
    logic rst;
    neokeon_decrypt_core_if bus ();

    neokeon_decrypt_core #(.ROUNDS(16)) dut (
        .inClk (clk),
        .inRst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic w_t rl(input w_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Round constants from the LFSR definition rather than a table.
    function automatic logic [7:0] m_rc(input int i);
        logic [7:0] x;
        x = 8'h80;
        for (int j = 0; j < i; j++) x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        return x;
    endfunction

    function automatic logic [127:0] m_theta(input logic [127:0] k, input logic [127:0] s);
        w_t a[4];
        w_t kw[4];
        w_t t;
        {a[0], a[1], a[2], a[3]} = s;
        {kw[0], kw[1], kw[2], kw[3]} = k;
        t = a[0] ^ a[2];
        t = t ^ rl(t, 8) ^ rl(t, 24);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= kw[i];
        t = a[1] ^ a[3];
        t = t ^ rl(t, 8) ^ rl(t, 24);
        a[0] ^= t;
        a[2] ^= t;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_nonlin(input logic [127:0] s);
        w_t a[4];
        w_t t;
        {a[0], a[1], a[2], a[3]} = s;
        a[1] = rl(a[1], 1);
        a[2] = rl(a[2], 5);
        a[3] = rl(a[3], 2);
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        t = a[3];
        a[3] = a[0];
        a[0] = t;
        a[2] ^= a[0] ^ a[1] ^ a[3];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        a[1] = rl(a[1], 31);
        a[2] = rl(a[2], 27);
        a[3] = rl(a[3], 30);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s;
        s = p;
        for (int r = 0; r < 16; r++) begin
            s[103:96] ^= m_rc(r);
            s = m_nonlin(m_theta(k, s));
        end
        s[103:96] ^= m_rc(16);
        return m_theta(k, s);
    endfunction

    function automatic logic [127:0] m_dec(input logic [127:0] k, input logic [127:0] c);
        logic [127:0] s;
        logic [127:0] wk;
        wk = m_theta('0, k);
        s = c;
        for (int r = 16; r >= 1; r--) begin
            s = m_theta(wk, s);
            s[103:96] ^= m_rc(r);
            s = m_nonlin(s);
        end
        s = m_theta(wk, s);
        s[103:96] ^= m_rc(0);
        return s;
    endfunction

    // Transaction-level timing model: count down from acceptance to the done pulse.
    int           m_cnt = 0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    logic [127:0] m_out = '0;
    logic [127:0] m_res = '0;
    bit           m_cv = 1'b0;
    logic [127:0] m_ck = '0;

    initial begin
        bit acc;
        bit hit;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt  = 0;
                m_busy = 1'b0;
                m_done = 1'b0;
                m_out  = '0;
                m_cv   = 1'b0;
            end else begin
                acc    = bus.inStart && !m_busy;
                m_done = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_done = 1'b1;
                        m_out  = m_res;
                    end
                end else if (acc) begin
                    hit   = CacheEn && m_cv && (bus.inKey == m_ck);
                    m_cnt = hit ? 17 : 18;
                    m_cv  = 1'b1;
                    m_ck  = bus.inKey;
                    m_res = m_dec(bus.inKey, bus.inDataState);
                end
                m_busy = (m_cnt > 0) || m_done;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_busy", 128'(bus.outBusy), 128'(m_busy));
                check("cyc_done", 128'(bus.outDone), 128'(m_done));
                check("cyc_out", bus.outDataState, m_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [127:0] k, input logic [127:0] c);
        @(negedge clk);
        bus.inStart     = 1'b1;
        bus.inKey       = k;
        bus.inDataState = c;
        @(negedge clk);
        bus.inStart     = 1'b0;
        bus.inKey       = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.inDataState = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_done(output logic [127:0] res, output int lat);
        lat = 1;
        while (bus.outDone !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", 128'(bus.outDone), 128'(1));
        res = bus.outDataState;
    endtask

    task automatic run_op(input logic [127:0] k, input logic [127:0] c,
                          output logic [127:0] res, output int lat);
        pulse_start(k, c);
        wait_done(res, lat);
    endtask

    initial begin
        logic [127:0] res, k, p, p2, ct, ct2, prev_k;
        int lat;
        rst = 1'b1;
        bus.inStart = 1'b0;
        bus.inKey = '0;
        bus.inDataState = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 128'(bus.outBusy), 128'(0));
        check("reset_done", 128'(bus.outDone), 128'(0));
        check("reset_out", bus.outDataState, 128'h0);
        rst = 1'b0;

        // Pin the model to the published direct-key vector.
        check("model_enc_kat", m_enc('0, '0), KatCt);
        check("model_dec_kat", m_dec('0, KatCt), 128'h0);

        // Known answer
        run_op('0, KatCt, res, lat);
        check("kat_out", res, 128'h0);
        check("kat_lat", 128'(lat), 128'(19));

        // Round trip through the model's encryptor
        run_op(RtKey, m_enc(RtKey, RtPt), res, lat);
        check("rt_out", res, RtPt);
        check("rt_lat", 128'(lat), 128'(19));

        // Starts while busy, in the done cycle, then the cycle after
        p   = 128'h00112233445566778899aabbccddeeff;
        p2  = 128'hfedcba98765432100123456789abcdef;
        ct  = m_enc(128'h1, p);
        ct2 = m_enc(128'h2, p2);
        @(negedge clk);
        bus.inStart = 1'b1;
        bus.inKey = 128'h1;
        bus.inDataState = ct;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            bus.inStart = (c == 5 || c == 18 || c == 19 || c == 20);
            bus.inKey = 128'h2;
            bus.inDataState = ct2;
            if (c == 19) begin
                check("busy_test_done", 128'(bus.outDone), 128'(1));
                check("busy_test_out", bus.outDataState, p);
            end
            if (c == 20) check("b2b_refused", 128'(bus.outBusy), 128'(0));
            if (c == 21) check("b2b_accepted", 128'(bus.outBusy), 128'(1));
        end
        bus.inStart = 1'b0;
        wait_done(res, lat);
        check("b2b_out", res, p2);
        check("b2b_lat", 128'(lat), 128'(19));

        // Reset in the middle of an operation
        pulse_start(RtKey, m_enc(RtKey, RtPt));
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 128'(bus.outBusy), 128'(0));
        check("midrst_done", 128'(bus.outDone), 128'(0));
        check("midrst_out", bus.outDataState, 128'h0);
        run_op('0, KatCt, res, lat);
        check("post_rst_out", res, 128'h0);
        check("post_rst_lat", 128'(lat), 128'(19));

        // Same key twice, then a different key
        k = 128'hcafef00d_0badc0de_13579bdf_2468ace0;
        run_op(k, m_enc(k, 128'h1), res, lat);
        check("cache1_out", res, 128'h1);
        check("cache1_lat", 128'(lat), 128'(19));
        run_op(k, m_enc(k, 128'h2), res, lat);
        check("cache2_out", res, 128'h2);
        check("cache2_lat", 128'(lat), CacheEn ? 128'(18) : 128'(19));
        k = ~k;
        run_op(k, m_enc(k, 128'h3), res, lat);
        check("cache3_out", res, 128'h3);
        check("cache3_lat", 128'(lat), 128'(19));

        // Random regression with occasional key reuse and idle gaps
        prev_k = k;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) k = prev_k;
            else k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = m_enc(k, p);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_op(k, ct, res, lat);
            check("rand_out", res, p);
            prev_k = k;
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
